// File: rtl/pool_window_scheduler.sv
// Read-side window sequencer for the pooling row-ring buffer: walks every pooling window,
// frames reads for the vector_max lanes and returns row slots. Optional POOL_SCHED_PERF_EN adds perf counters.
module pool_window_scheduler #(
    parameter int W_OUT     = 16,
    parameter int H_OUT     = 16,
    parameter int WIN_W     = 2,
    parameter int WIN_H     = 2,
    parameter int STRIDE    = 2,
    parameter int ROW_WORDS = 32,
    parameter int RING_ROWS = 4,
    parameter int ADDR_W    = 10,
    parameter int DATA_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              row_done,
    output logic              row_free,
    output logic [ADDR_W-1:0] rm_rd_addr,
    output logic              op_din_en,
    output logic              op_din_eop,
    input  logic              blob_dout_rdy,
    output logic              blob_dout_en,
    output logic              blob_dout_eop,
    output logic              busy,
    output logic              err_ovf
`ifdef POOL_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_win_cnt
`endif
);

    localparam int RH_W = $clog2(RING_ROWS + 1);
    localparam int KX_W = $clog2(WIN_W + 1);
    localparam int KY_W = $clog2(WIN_H + 1);
    localparam int OX_W = $clog2(W_OUT + 1);
    localparam int OY_W = $clog2(H_OUT + 1);

    localparam logic [KX_W-1:0]   KX_LAST     = KX_W'(WIN_W - 1);
    localparam logic [KY_W-1:0]   KY_LAST     = KY_W'(WIN_H - 1);
    localparam logic [OX_W-1:0]   OX_LAST     = OX_W'(W_OUT - 1);
    localparam logic [OY_W-1:0]   OY_LAST     = OY_W'(H_OUT - 1);
    localparam logic [RH_W-1:0]   RING_FULL   = RH_W'(RING_ROWS);
    localparam logic [RH_W-1:0]   WINH_RH     = RH_W'(WIN_H);
    localparam logic [RH_W-1:0]   STRIDE_RH   = RH_W'(STRIDE);
    localparam logic [ADDR_W-1:0] COL_STEP    = ADDR_W'(STRIDE);
    localparam logic [ADDR_W:0]   ROW_STEP    = (ADDR_W + 1)'(ROW_WORDS);
    localparam logic [ADDR_W:0]   STRIDE_STEP = (ADDR_W + 1)'(STRIDE * ROW_WORDS);
    localparam logic [ADDR_W:0]   WINH_STEP   = (ADDR_W + 1)'(WIN_H * ROW_WORDS);
    localparam logic [ADDR_W:0]   RING_WORDS  = (ADDR_W + 1)'(RING_ROWS * ROW_WORDS);

    typedef enum logic [1:0] {ST_WAIT, ST_ISSUE, ST_RELEASE} state_t;

    state_t              state;
    logic [KX_W-1:0]     kx;
    logic [KY_W-1:0]     ky;
    logic [OX_W-1:0]     ox;
    logic [OY_W-1:0]     oy;
    logic [RH_W-1:0]     rows_held;
    logic [RH_W-1:0]     rel_cnt;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W-1:0]   slot_addr;
    logic [ADDR_W-1:0]   col_addr;
    logic                eop_frame;
    logic [DATA_LAT-1:0] dl_en;
    logic [DATA_LAT-1:0] dl_last;

    logic                win_ready, next_win, ox_last, row_last, last_read, issue, issue_ox_last;
    logic [ADDR_W-1:0]   issue_col;
    logic [RH_W-1:0]     rel_n;
    logic [ADDR_W:0]     base_step;

    // Slot addresses stay pre-multiplied by ROW_WORDS and wrap with one subtraction.
    function automatic logic [ADDR_W-1:0] ring_add(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] inc);
        logic [ADDR_W:0] s;
        s = {1'b0, a} + inc;
        if (s >= RING_WORDS) s = s - RING_WORDS;
        return s[ADDR_W-1:0];
    endfunction

    always_comb begin
        win_ready     = (rows_held >= WINH_RH) && blob_dout_rdy;
        next_win      = (state == ST_ISSUE) && op_din_eop;
        ox_last       = (ox == OX_LAST);
        row_last      = (oy == OY_LAST);
        last_read     = (kx == KX_LAST) && (ky == KY_LAST);
        issue         = 1'b0;
        case (state)
            ST_WAIT:  issue = win_ready;
            ST_ISSUE: issue = !op_din_eop || (!ox_last && blob_dout_rdy);
            default:  issue = 1'b0;
        endcase
        issue_col     = next_win ? col_addr + COL_STEP : col_addr;
        issue_ox_last = next_win ? ((ox + OX_W'(1)) == OX_LAST) : ox_last;
        rel_n         = row_last ? WINH_RH : STRIDE_RH;
        base_step     = row_last ? WINH_STEP : STRIDE_STEP;
    end

    // Window walker: kx/ky/slot_addr always point at the next read to issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_WAIT;
            kx         <= '0;
            ky         <= '0;
            ox         <= '0;
            oy         <= '0;
            rel_cnt    <= '0;
            base_addr  <= '0;
            slot_addr  <= '0;
            col_addr   <= '0;
            rm_rd_addr <= '0;
            op_din_en  <= 1'b0;
            op_din_eop <= 1'b0;
            eop_frame  <= 1'b0;
            row_free   <= 1'b0;
        end else begin
            op_din_en  <= issue;
            op_din_eop <= issue && last_read;
            eop_frame  <= issue && last_read && issue_ox_last && row_last;
            if (issue) begin
                rm_rd_addr <= slot_addr + issue_col + ADDR_W'(kx);
                if (kx == KX_LAST) begin
                    kx <= '0;
                    if (ky == KY_LAST) begin
                        ky        <= '0;
                        slot_addr <= base_addr;
                    end else begin
                        ky        <= ky + KY_W'(1);
                        slot_addr <= ring_add(slot_addr, ROW_STEP);
                    end
                end else begin
                    kx <= kx + KX_W'(1);
                end
            end
            case (state)
                ST_WAIT: begin
                    if (win_ready) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (op_din_eop) begin
                        if (!ox_last) begin
                            ox       <= ox + OX_W'(1);
                            col_addr <= issue_col;
                            if (!blob_dout_rdy) state <= ST_WAIT;
                        end else begin
                            ox       <= '0;
                            col_addr <= '0;
                            row_free <= 1'b1;
                            rel_cnt  <= RH_W'(1);
                            state    <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (rel_cnt == rel_n) begin
                        row_free  <= 1'b0;
                        base_addr <= ring_add(base_addr, base_step);
                        slot_addr <= ring_add(base_addr, base_step);
                        oy        <= row_last ? '0 : oy + OY_W'(1);
                        state     <= ST_WAIT;
                    end else begin
                        rel_cnt <= rel_cnt + RH_W'(1);
                    end
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

    // A simultaneous row_done and row_free leave the occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rows_held <= '0;
            err_ovf   <= 1'b0;
        end else if (row_done && !row_free) begin
            if (rows_held == RING_FULL) err_ovf <= 1'b1;
            else rows_held <= rows_held + RH_W'(1);
        end else if (row_free && !row_done && rows_held != '0) begin
            rows_held <= rows_held - RH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_en   <= '0;
            dl_last <= '0;
        end else begin
            dl_en[0]   <= op_din_eop;
            dl_last[0] <= eop_frame;
            for (int i = 1; i < DATA_LAT; i++) begin
                dl_en[i]   <= dl_en[i-1];
                dl_last[i] <= dl_last[i-1];
            end
        end
    end

    assign blob_dout_en  = dl_en[DATA_LAT-1];
    assign blob_dout_eop = dl_en[DATA_LAT-1] & dl_last[DATA_LAT-1];
    assign busy          = (state != ST_WAIT) || (|dl_en);

`ifdef POOL_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_win_cnt   <= '0;
        end else begin
            if (state == ST_WAIT && rows_held >= WINH_RH && !blob_dout_rdy)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (op_din_eop)
                perf_win_cnt <= perf_win_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pool_window_scheduler.sv
// Directed bench for pool_window_scheduler on a 2x2 output map with 2x2 windows, stride 2, 4-slot ring.
module tb_pool_window_scheduler;

    localparam int W_OUT = 2, H_OUT = 2, WIN_W = 2, WIN_H = 2, STRIDE = 2;
    localparam int ROW_WORDS = 4, RING_ROWS = 4, ADDR_W = 4, DATA_LAT = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              row_done = 1'b0;
    logic              blob_dout_rdy = 1'b1;
    logic              row_free, op_din_en, op_din_eop, blob_dout_en, blob_dout_eop, busy, err_ovf;
    logic [ADDR_W-1:0] rm_rd_addr;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int held_m = 0;
    int held_max = 0;
    int rd_addr_q[$], rd_eop_q[$], rd_cyc_q[$], eop_cyc_q[$], out_cyc_q[$], out_eop_q[$], free_cyc_q[$];
    int exp_a[16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

    always #5 clk = ~clk;

    pool_window_scheduler #(
        .W_OUT(W_OUT), .H_OUT(H_OUT), .WIN_W(WIN_W), .WIN_H(WIN_H), .STRIDE(STRIDE),
        .ROW_WORDS(ROW_WORDS), .RING_ROWS(RING_ROWS), .ADDR_W(ADDR_W), .DATA_LAT(DATA_LAT)
    ) dut (
        .clk(clk), .rst(rst), .row_done(row_done), .row_free(row_free), .rm_rd_addr(rm_rd_addr),
        .op_din_en(op_din_en), .op_din_eop(op_din_eop), .blob_dout_rdy(blob_dout_rdy),
        .blob_dout_en(blob_dout_en), .blob_dout_eop(blob_dout_eop), .busy(busy), .err_ovf(err_ovf)
    );

    // Cycle counter and upstream occupancy model (row_done minus row_free).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) held_m <= 0;
        else held_m <= held_m + int'(row_done) - int'(row_free);
    end

    // Event logger sampled mid-cycle.
    always @(negedge clk) begin
        if (op_din_en) begin
            rd_addr_q.push_back(int'(rm_rd_addr));
            rd_eop_q.push_back(int'(op_din_eop));
            rd_cyc_q.push_back(cyc);
        end
        if (op_din_eop) eop_cyc_q.push_back(cyc);
        if (blob_dout_en) begin
            out_cyc_q.push_back(cyc);
            out_eop_q.push_back(int'(blob_dout_eop));
        end
        if (row_free) free_cyc_q.push_back(cyc);
        if (rst) held_max <= 0;
        else if (held_m > held_max) held_max <= held_m;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_logs();
        rd_addr_q.delete(); rd_eop_q.delete(); rd_cyc_q.delete(); eop_cyc_q.delete();
        out_cyc_q.delete(); out_eop_q.delete(); free_cyc_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        row_done = 1'b0;
        blob_dout_rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_rows(input int n);
        for (int i = 0; i < n; i++) begin
            row_done = 1'b1;
            @(negedge clk);
        end
        row_done = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int quiet = 0;
        int t = 0;
        while (quiet < 6 && t < budget) begin
            @(negedge clk);
            t++;
            if (!busy && !op_din_en && !row_free) quiet++;
            else quiet = 0;
        end
        n_cmp++;
        if (quiet < 6) begin
            n_mis++;
            $display("[TB] FAIL %s_idle: busy=%0b after %0d cycles, required 0", tag, busy, t);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({row_free, rm_rd_addr, op_din_en, op_din_eop, blob_dout_en, blob_dout_eop, busy, err_ovf} !== '0) begin
            n_mis++;
            $display("[TB] FAIL reset_outputs: got free=%0b addr=%0d en=%0b eop=%0b out=%0b oeop=%0b busy=%0b ovf=%0b, required all 0",
                     row_free, rm_rd_addr, op_din_en, op_din_eop, blob_dout_en, blob_dout_eop, busy, err_ovf);
        end
    endtask

    task automatic test_full_frame();
        int k;
        do_reset();
        clear_logs();
        k = cyc;
        pulse_rows(4);
        wait_idle(300, "full_frame");
        n_cmp++;
        if (rd_addr_q.size() !== 16) begin
            n_mis++;
            $display("[TB] FAIL frame_reads: got %0d reads, required 16", rd_addr_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (rd_addr_q[i] !== exp_a[i]) begin
                    n_mis++;
                    $display("[TB] FAIL frame_addr[%0d]: got %0d, required %0d", i, rd_addr_q[i], exp_a[i]);
                end
                n_cmp++;
                if (rd_eop_q[i] !== int'(i % 4 == 3)) begin
                    n_mis++;
                    $display("[TB] FAIL frame_eop[%0d]: got %0d, required %0d", i, rd_eop_q[i], int'(i % 4 == 3));
                end
            end
            n_cmp++;
            if (rd_cyc_q[0] !== k + 3) begin
                n_mis++;
                $display("[TB] FAIL frame_first_read_cycle: got %0d, required %0d", rd_cyc_q[0], k + 3);
            end
            n_cmp++;
            if (rd_cyc_q[7] - rd_cyc_q[0] !== 7) begin
                n_mis++;
                $display("[TB] FAIL frame_row_no_bubble: got span %0d, required 7", rd_cyc_q[7] - rd_cyc_q[0]);
            end
        end
        n_cmp++;
        if (free_cyc_q.size() !== 4) begin
            n_mis++;
            $display("[TB] FAIL frame_free_count: got %0d, required 4", free_cyc_q.size());
        end else if (rd_cyc_q.size() == 16 && eop_cyc_q.size() == 4) begin
            n_cmp++;
            if (!(free_cyc_q[1] == free_cyc_q[0] + 1 && free_cyc_q[3] == free_cyc_q[2] + 1 &&
                  free_cyc_q[0] > eop_cyc_q[1] && free_cyc_q[1] < rd_cyc_q[8] && free_cyc_q[2] > eop_cyc_q[3])) begin
                n_mis++;
                $display("[TB] FAIL frame_free_timing: got frees at %0d,%0d,%0d,%0d, required pairs after each row",
                         free_cyc_q[0], free_cyc_q[1], free_cyc_q[2], free_cyc_q[3]);
            end
        end
        n_cmp++;
        if (out_cyc_q.size() !== 4 || eop_cyc_q.size() !== 4) begin
            n_mis++;
            $display("[TB] FAIL frame_out_count: got %0d outputs / %0d eops, required 4 / 4", out_cyc_q.size(), eop_cyc_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (out_cyc_q[i] - eop_cyc_q[i] !== DATA_LAT) begin
                    n_mis++;
                    $display("[TB] FAIL frame_out_lat[%0d]: got %0d, required %0d", i, out_cyc_q[i] - eop_cyc_q[i], DATA_LAT);
                end
                n_cmp++;
                if (out_eop_q[i] !== int'(i == 3)) begin
                    n_mis++;
                    $display("[TB] FAIL frame_out_eop[%0d]: got %0d, required %0d", i, out_eop_q[i], int'(i == 3));
                end
            end
        end
    endtask

    task automatic test_starvation();
        int k;
        do_reset();
        clear_logs();
        pulse_rows(1);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rd_addr_q.size() !== 0 || busy !== 1'b0) begin
            n_mis++;
            $display("[TB] FAIL starve_idle: got %0d reads busy=%0b, required 0 reads busy=0", rd_addr_q.size(), busy);
        end
        k = cyc;
        pulse_rows(1);
        wait_idle(200, "starve");
        n_cmp++;
        if (rd_addr_q.size() !== 8) begin
            n_mis++;
            $display("[TB] FAIL starve_reads: got %0d, required 8", rd_addr_q.size());
        end else begin
            n_cmp++;
            if (rd_cyc_q[0] !== k + 2) begin
                n_mis++;
                $display("[TB] FAIL starve_first_read_cycle: got %0d, required %0d", rd_cyc_q[0], k + 2);
            end
        end
        n_cmp++;
        if (free_cyc_q.size() !== 2 || out_cyc_q.size() !== 2 || out_eop_q.sum() !== 0) begin
            n_mis++;
            $display("[TB] FAIL starve_row: got frees=%0d outs=%0d out_eops=%0d, required 2/2/0",
                     free_cyc_q.size(), out_cyc_q.size(), out_eop_q.sum());
        end
    endtask

    task automatic test_backpressure();
        int k, m;
        do_reset();
        clear_logs();
        blob_dout_rdy = 1'b0;
        pulse_rows(4);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rd_addr_q.size() !== 0 || busy !== 1'b0) begin
            n_mis++;
            $display("[TB] FAIL bp_hold: got %0d reads busy=%0b, required 0 reads busy=0", rd_addr_q.size(), busy);
        end
        blob_dout_rdy = 1'b1;
        k = cyc;
        repeat (2) @(negedge clk);
        blob_dout_rdy = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (rd_addr_q.size() !== 4 || out_cyc_q.size() !== 1 || eop_cyc_q.size() !== 1) begin
            n_mis++;
            $display("[TB] FAIL bp_one_window: got reads=%0d outs=%0d, required 4/1", rd_addr_q.size(), out_cyc_q.size());
        end else begin
            n_cmp++;
            if (rd_cyc_q[0] !== k + 1) begin
                n_mis++;
                $display("[TB] FAIL bp_start_cycle: got %0d, required %0d", rd_cyc_q[0], k + 1);
            end
            n_cmp++;
            if (out_cyc_q[0] - eop_cyc_q[0] !== DATA_LAT) begin
                n_mis++;
                $display("[TB] FAIL bp_inflight_lat: got %0d, required %0d", out_cyc_q[0] - eop_cyc_q[0], DATA_LAT);
            end
        end
        blob_dout_rdy = 1'b1;
        m = cyc;
        wait_idle(300, "bp");
        n_cmp++;
        if (rd_addr_q.size() !== 16 || out_cyc_q.size() !== 4) begin
            n_mis++;
            $display("[TB] FAIL bp_frame: got reads=%0d outs=%0d, required 16/4", rd_addr_q.size(), out_cyc_q.size());
        end else begin
            n_cmp++;
            if (rd_cyc_q[4] !== m + 1 || rd_addr_q[4] !== 2) begin
                n_mis++;
                $display("[TB] FAIL bp_resume: got cycle %0d addr %0d, required cycle %0d addr 2", rd_cyc_q[4], rd_addr_q[4], m + 1);
            end
            n_cmp++;
            if (out_eop_q[3] !== 1) begin
                n_mis++;
                $display("[TB] FAIL bp_frame_eop: got %0d, required 1", out_eop_q[3]);
            end
        end
    endtask

    task automatic test_ring_wrap();
        int sent = 0;
        int quiet = 0;
        int t = 0;
        do_reset();
        clear_logs();
        pulse_rows(4);
        while ((sent < 4 || quiet < 6) && t < 600) begin
            @(negedge clk);
            t++;
            if (row_free && sent < 4) begin
                row_done = 1'b1;
                sent++;
            end else begin
                row_done = 1'b0;
            end
            if (!busy && !op_din_en && !row_free) quiet++;
            else quiet = 0;
        end
        row_done = 1'b0;
        n_cmp++;
        if (quiet < 6) begin
            n_mis++;
            $display("[TB] FAIL wrap_idle: busy=%0b after %0d cycles, required 0", busy, t);
        end
        n_cmp++;
        if (rd_addr_q.size() !== 32) begin
            n_mis++;
            $display("[TB] FAIL wrap_reads: got %0d, required 32", rd_addr_q.size());
        end else begin
            for (int i = 16; i < 32; i++) begin
                n_cmp++;
                if (rd_addr_q[i] !== exp_a[i-16]) begin
                    n_mis++;
                    $display("[TB] FAIL wrap_addr[%0d]: got %0d, required %0d", i, rd_addr_q[i], exp_a[i-16]);
                end
            end
        end
        n_cmp++;
        if (out_cyc_q.size() !== 8 || out_eop_q.sum() !== 2 || free_cyc_q.size() !== 8) begin
            n_mis++;
            $display("[TB] FAIL wrap_outputs: got outs=%0d frame_eops=%0d frees=%0d, required 8/2/8",
                     out_cyc_q.size(), out_eop_q.sum(), free_cyc_q.size());
        end
        n_cmp++;
        if (held_max > RING_ROWS || err_ovf !== 1'b0) begin
            n_mis++;
            $display("[TB] FAIL wrap_occupancy: got max held %0d ovf=%0b, required <=%0d ovf=0", held_max, err_ovf, RING_ROWS);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        clear_logs();
        blob_dout_rdy = 1'b0;
        pulse_rows(4);
        n_cmp++;
        if (err_ovf !== 1'b0) begin
            n_mis++;
            $display("[TB] FAIL ovf_at_full: got %0b, required 0", err_ovf);
        end
        pulse_rows(1);
        n_cmp++;
        if (err_ovf !== 1'b1) begin
            n_mis++;
            $display("[TB] FAIL ovf_set: got %0b, required 1", err_ovf);
        end
        n_cmp++;
        if (dut.rows_held !== 3'd4) begin
            n_mis++;
            $display("[TB] FAIL ovf_saturate: got rows_held %0d, required 4", dut.rows_held);
        end
        blob_dout_rdy = 1'b1;
        wait_idle(300, "ovf");
        n_cmp++;
        if (rd_addr_q.size() !== 16 || err_ovf !== 1'b1) begin
            n_mis++;
            $display("[TB] FAIL ovf_sticky: got reads=%0d ovf=%0b, required 16/1", rd_addr_q.size(), err_ovf);
        end
        do_reset();
        n_cmp++;
        if (err_ovf !== 1'b0) begin
            n_mis++;
            $display("[TB] FAIL ovf_clear: got %0b, required 0", err_ovf);
        end
    endtask

    task automatic test_reset_mid_window();
        int t = 0;
        do_reset();
        clear_logs();
        pulse_rows(2);
        while (!op_din_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (op_din_en !== 1'b1 || rm_rd_addr !== 4'd0) begin
            n_mis++;
            $display("[TB] FAIL rstmid_first_read: got en=%0b addr=%0d, required en=1 addr=0", op_din_en, rm_rd_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (op_din_en !== 1'b1 || rm_rd_addr !== 4'd1) begin
            n_mis++;
            $display("[TB] FAIL rstmid_second_read: got en=%0b addr=%0d, required en=1 addr=1", op_din_en, rm_rd_addr);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({op_din_en, op_din_eop, rm_rd_addr, busy} !== '0) begin
            n_mis++;
            $display("[TB] FAIL rstmid_outputs: got en=%0b eop=%0b addr=%0d busy=%0b, required all 0",
                     op_din_en, op_din_eop, rm_rd_addr, busy);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (rd_addr_q.size() !== 2 || out_cyc_q.size() !== 0) begin
            n_mis++;
            $display("[TB] FAIL rstmid_dropped: got reads=%0d outs=%0d, required 2/0", rd_addr_q.size(), out_cyc_q.size());
        end
        pulse_rows(2);
        wait_idle(200, "rstmid");
        n_cmp++;
        if (rd_addr_q.size() !== 10 || out_cyc_q.size() !== 2) begin
            n_mis++;
            $display("[TB] FAIL rstmid_resume_count: got reads=%0d outs=%0d, required 10/2", rd_addr_q.size(), out_cyc_q.size());
        end else begin
            n_cmp++;
            if (rd_addr_q[2] !== 0) begin
                n_mis++;
                $display("[TB] FAIL rstmid_resume_addr: got %0d, required 0", rd_addr_q[2]);
            end
        end
    endtask

    initial begin
        $display("[TB] pool_window_scheduler directed bench start");
        test_reset();
        test_full_frame();
        test_starvation();
        test_backpressure();
        test_ring_wrap();
        test_overflow();
        test_reset_mid_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pool_window_scheduler.md
# pool_window_scheduler

Read-side sequencer for the pooling layers' row-ring buffer. It tracks how many input rows the upstream writer has committed. It walks every pooling window of the output map, driving the ring-buffer read address and the `op_din_en`/`op_din_eop` strobes that frame each window for the per-lane `vector_max` units. It returns freed row slots to the writer and emits the output-word strobe with downstream backpressure gating.

## Interface
Parameters:
- `W_OUT`, 16: output map width (windows per output row)
- `H_OUT`, 16: output map height (output rows per frame)
- `WIN_W`, 2: window width
- `WIN_H`, 2: window height
- `STRIDE`, 2: window stride, both axes
- `ROW_WORDS`, 32: ring words per row slot; must be ≥ (W_OUT-1)*STRIDE+WIN_W
- `RING_ROWS`, 4: row slots in ring; must be ≥ WIN_H+STRIDE
- `ADDR_W`, 10: read address width; 2^ADDR_W ≥ RING_ROWS*ROW_WORDS
- `DATA_LAT`, 2: cycles from a window's `op_din_eop` to its `blob_dout_en` (RAM read latency + op delay)

Ports:
- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `row_done` in 1: one-cycle pulse, upstream finished writing one row slot
- `row_free` out 1: one-cycle pulse, one row slot released to upstream
- `rm_rd_addr` out ADDR_W: ring-buffer read address
- `op_din_en` out 1: read/operand valid
- `op_din_eop` out 1: last read of current window
- `blob_dout_rdy` in 1: downstream can accept outputs
- `blob_dout_en` out 1: output word valid
- `blob_dout_eop` out 1: last output word of frame (with `blob_dout_en`)
- `busy` out 1: FSM not in WAIT, or delay line non-empty
- `err_ovf` out 1: sticky, `row_done` received while ring full

## Operation
- Reset values:
  - all outputs 0
  - `rows_held`=0, `base`=0, `ox`=`oy`=`kx`=`ky`=0
  - delay line empty
  - FSM=WAIT
- `rows_held` (width clog2(RING_ROWS+1)):
  - +1 per `row_done`, −1 per `row_free`; both in the same cycle → unchanged.
  - `row_done` at `rows_held`==RING_ROWS: counter saturates and `err_ovf` sets (cleared only by `rst`).
- Address (registered):
  - `rm_rd_addr` = ((`base`+`ky`) mod RING_ROWS)*ROW_WORDS + `ox`*STRIDE + `kx`.
  - Computed with incremental counters; no multiplier.
- FSM:
  - WAIT → ISSUE when `rows_held` ≥ WIN_H and `blob_dout_rdy`=1.
  - ISSUE runs WIN_W*WIN_H consecutive cycles with `op_din_en`=1. Loop order: `kx` inner, `ky` outer. `op_din_eop`=1 on the final read.
  - After the last read of a window with `ox` < W_OUT-1: `ox`++. If `blob_dout_rdy`=1, the next window's first read is in the following cycle (no bubble); otherwise → WAIT.
  - After the last read with `ox`==W_OUT-1: `ox`=0 → RELEASE.
  - RELEASE: pulse `row_free` on N consecutive cycles, then `base`=(`base`+N) mod RING_ROWS.
    - Non-last output row: N=STRIDE; `oy`++.
    - `oy`==H_OUT-1: N=WIN_H; `oy`=0 (frame end).
    - Either case → WAIT.
- Output strobes:
  - An internal delay line of depth DATA_LAT carries {en, frame_last} from each `op_din_eop`.
  - `blob_dout_en` pulses exactly DATA_LAT cycles after each `op_din_eop`.
  - `blob_dout_eop` accompanies the output of window (W_OUT-1, H_OUT-1).
- Backpressure: `blob_dout_rdy` gates only window starts. Downstream must absorb up to ceil(DATA_LAT/(WIN_W*WIN_H))+1 in-flight outputs after deasserting rdy.
- Frames run back-to-back; `base` continues around the ring across frames.

## Timing
- `op_din_en`/`op_din_eop`/`rm_rd_addr` are registered. The first read appears one cycle after the cycle in which the WAIT exit condition is true.
- Steady state with rdy=1 and rows available: one read per cycle; W_OUT*WIN_W*WIN_H cycles per output row, plus N RELEASE cycles.
- Reset mid-operation: all outputs 0 in the cycle after `rst` is sampled. The delay line is flushed, so in-flight outputs are dropped. Held rows are forgotten, and upstream is reset together with this block.
- `row_done` during ISSUE/RELEASE is counted normally; it never stalls the FSM.

## Configuration
- `POOL_SCHED_PERF_EN` defined: adds outputs `perf_stall_cnt` [31:0] and `perf_win_cnt` [31:0], both cleared by `rst`, wrapping at 2^32.
  - `perf_stall_cnt` counts WAIT cycles with `rows_held` ≥ WIN_H and `blob_dout_rdy`=0.
  - `perf_win_cnt` counts `op_din_eop` pulses.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

## Test plan
Common parameters: W_OUT=2, H_OUT=2, WIN=2×2, STRIDE=2, ROW_WORDS=4, RING_ROWS=4, DATA_LAT=2; `blob_dout_rdy`=1 unless stated.

- Full frame, 4 `row_done` pulses up front:
  - Addresses 0,1,4,5 | 2,3,6,7 | 8,9,12,13 | 10,11,14,15.
  - `op_din_eop` on every 4th read.
  - 2 `row_free` pulses after each output row.
  - `blob_dout_eop` with the 4th output, 2 cycles after the last `op_din_eop`.
- Row starvation: send only 1 `row_done` → no `op_din_en`, `busy`=0. Second `row_done` → first read one cycle after the window start is enabled.
- Backpressure: hold `blob_dout_rdy`=0 with 4 rows held → FSM stays in WAIT, zero reads. Raise rdy mid-row → next window starts; already-issued outputs still appear 2 cycles after their eop.
- Ring wrap: run two consecutive frames → second frame's first window reads 0,1,4,5 (`base` back to 0); `rows_held` never exceeds 4.
- Overflow: rdy=0, 5 `row_done` pulses → `err_ovf`=1, `rows_held`=4. `err_ovf` stays 1 until `rst`.
- Reset mid-window: assert `rst` on the 2nd read of a window → `op_din_en`=0 the next cycle, no `blob_dout_en` for that window, first read after resume is address 0.
